// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_pkg : shared encodings and types for the EX-stage MDU           |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mips_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_sign_fix.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mdu_sign_fix : conditional two's-complement negate                   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? ((~din) + {{(W-1){1'b0}}, 1'b1}) : din;

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mult_div_unit : iterative MULT/MULTU/DIV/DIVU into HI/LO             |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             sgn, a_neg, b_neg, is_div;
  logic [WIDTH-1:0] a_abs, b_abs, quo_fixed, rem_fixed;
  logic [2*WIDTH-1:0] prod_fixed;

  assign sgn    = op_is_signed(op);
  assign a_neg  = sgn & src_a[WIDTH-1];
  assign b_neg  = sgn & src_b[WIDTH-1];
  assign is_div = op_is_div(op_q);

  mdu_sign_fix #(.W(WIDTH)) u_a_abs (.neg(a_neg), .din(src_a), .dout(a_abs));
  mdu_sign_fix #(.W(WIDTH)) u_b_abs (.neg(b_neg), .din(src_b), .dout(b_abs));

  mdu_sign_fix #(.W(2*WIDTH)) u_prod_fix (
    .neg(neg_res_q), .din({acc_q, q_q}), .dout(prod_fixed)
  );
  mdu_sign_fix #(.W(WIDTH)) u_quo_fix (.neg(neg_res_q), .din(q_q), .dout(quo_fixed));
  mdu_sign_fix #(.W(WIDTH)) u_rem_fix (.neg(neg_rem_q), .din(acc_q), .dout(rem_fixed));

  // Shared adder: add for shift-add multiply, subtract for restoring divide.
  // In subtract mode bit WIDTH+1 of the sum is the "no borrow" flag.
  logic [WIDTH:0]   add_x, add_y;
  logic             add_sub;
  logic [WIDTH+1:0] add_sum;
  logic             no_borrow;

  always_comb begin
    add_x   = {1'b0, acc_q};
    add_y   = q_q[0] ? {1'b0, b_q} : '0;
    add_sub = 1'b0;
    if (is_div) begin
      add_x   = {acc_q, q_q[WIDTH-1]};
      add_y   = {1'b0, b_q};
      add_sub = 1'b1;
    end
  end

  assign add_sum   = {1'b0, add_x} + {1'b0, add_y ^ {(WIDTH+1){add_sub}}}
                   + {{(WIDTH+1){1'b0}}, add_sub};
  assign no_borrow = add_sum[WIDTH+1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    b_d       = b_q;
    acc_d     = acc_q;
    q_d       = q_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = op;
          acc_d     = '0;
          q_d       = a_abs;
          b_d       = b_abs;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dz_d      = (src_b == '0);
          cnt_d     = '0;
          state_d   = CALC;
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      CALC: begin
        if (is_div) begin
          acc_d = no_borrow ? add_sum[WIDTH-1:0] : add_x[WIDTH-1:0];
          q_d   = {q_q[WIDTH-2:0], no_borrow};
        end else begin
          acc_d = add_sum[WIDTH:1];
          q_d   = {add_sum[0], q_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        // A zero divisor leaves the dividend in the remainder, so HI is
        // already correct; only LO needs forcing.
        if (is_div) begin
          lo_d = dz_q ? '1 : quo_fixed;
          hi_d = rem_fixed;
        end else begin
          {hi_d, lo_d} = prod_fixed;
        end
        done_d  = 1'b1;
        dbz_d   = is_div & dz_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mult_div_unit : directed and random checks of mult_div_unit       |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mult_div_unit;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] src_a = '0, src_b = '0, wdata = '0;
  logic         hi_we = 1'b0, lo_we = 1'b0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, SV division truncates toward zero.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el, output logic ed);
    longint sa, sb, sq, sr;
    logic [63:0] p, tq, tr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ed = 1'b0;
    case (o)
      2'b00: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; eh = p[63:32]; el = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          el = 32'hFFFF_FFFF; eh = a; ed = 1'b1;
        end else if (o == 2'b10) begin
          sq = sa / sb; sr = sa % sb;
          tq = sq; tr = sr;
          el = tq[31:0]; eh = tr[31:0];
        end else begin
          el = a / b; eh = a % b;
        end
      end
    endcase
  endtask

  // Issues one operation and checks latency, busy window and results.
  // now_=1 asserts start immediately (used from inside a done cycle).
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                       input logic ed, input bit now_);
    int edges, busy_cnt;
    if (!now_) @(negedge CLK);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    src_a = $urandom; src_b = $urandom;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    edges = 0;
    while (done !== 1'b1 && edges < 100) begin
      @(posedge CLK); #1;
      edges++;
      if (busy === 1'b1) busy_cnt++;
    end
    check({tag, " latency"}, 64'(edges), 64'd33);
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
    check({tag, " busy_at_done"}, {63'd0, busy}, 64'd0);
    check({tag, " hi"}, {32'd0, hi}, {32'd0, eh});
    check({tag, " lo"}, {32'd0, lo}, {32'd0, el});
    check({tag, " dbz"}, {63'd0, div_by_zero}, {63'd0, ed});
  endtask

  initial begin
    logic [31:0] ra, rb, eh, el;
    logic [1:0]  ro;
    logic        ed;
    int          edges, seen;

    repeat (2) @(posedge CLK);
    #1;
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset dbz", {63'd0, div_by_zero}, 64'd0);
    check("reset hi", {32'd0, hi}, 64'd0);
    check("reset lo", {32'd0, lo}, 64'd0);
    @(negedge CLK); RST = 1'b0;

    do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
    do_op("mult_neg", 2'b00, -32'sd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b0);
    do_op("mult_b2b", 2'b00, 32'd7, -32'sd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0, 1'b1);
    do_op("div_neg", 2'b10, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b0);
    do_op("divu_zero", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1, 1'b0);
    do_op("div_zero", 2'b10, -32'sd9, 32'd0, -32'sd9, 32'hFFFF_FFFF, 1'b1, 1'b1);

    for (int i = 0; i < 12; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom; rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 9));
      if ($urandom_range(0, 5) == 0) ra = -32'sd1;
      model(ro, ra, rb, eh, el, ed);
      do_op("random", ro, ra, rb, eh, el, ed, bit'($urandom_range(0, 1)));
    end

    // Start and MTHI while busy must both be dropped.
    @(negedge CLK);
    op = 2'b01; src_a = 32'd9; src_b = 32'd9; start = 1'b1;
    @(posedge CLK); #1; start = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    op = 2'b10; src_a = 32'd100; src_b = 32'd3; start = 1'b1; hi_we = 1'b1; wdata = 32'h1234;
    @(posedge CLK); #1;
    start = 1'b0; hi_we = 1'b0;
    edges = 5;
    while (done !== 1'b1 && edges < 100) begin @(posedge CLK); #1; edges++; end
    check("busy_ign latency", 64'(edges), 64'd33);
    check("busy_ign lo", {32'd0, lo}, 64'd81);
    check("busy_ign hi", {32'd0, hi}, 64'd0);
    @(posedge CLK); #1;
    check("busy_ign no_restart", {63'd0, busy}, 64'd0);

    // Reset in the middle of an operation.
    @(negedge CLK);
    op = 2'b01; src_a = 32'd12345; src_b = 32'd678; start = 1'b1;
    @(posedge CLK); #1; start = 1'b0;
    repeat (10) @(posedge CLK);
    #1; RST = 1'b1;
    #2;
    check("midrst busy", {63'd0, busy}, 64'd0);
    RST = 1'b0;
    check("midrst hi", {32'd0, hi}, 64'd0);
    check("midrst lo", {32'd0, lo}, 64'd0);
    seen = 0;
    repeat (40) begin @(posedge CLK); #1; if (done === 1'b1 || busy === 1'b1) seen++; end
    check("midrst no_done", 64'(seen), 64'd0);

    // MTHI alone, then MTHI+MTLO together.
    @(negedge CLK);
    hi_we = 1'b1; wdata = 32'h1234;
    @(posedge CLK); #1; hi_we = 1'b0;
    check("mthi hi", {32'd0, hi}, 64'h1234);
    check("mthi lo", {32'd0, lo}, 64'd0);
    check("mthi done", {63'd0, done}, 64'd0);
    @(negedge CLK);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
    @(posedge CLK); #1; hi_we = 1'b0; lo_we = 1'b0;
    check("mthilo hi", {32'd0, hi}, 64'hCAFE_F00D);
    check("mthilo lo", {32'd0, lo}, 64'hCAFE_F00D);
    check("mthilo done", {63'd0, done}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
